// File: rtl/switch_debounce.sv
// Per-bit synchroniser and stability-counter debouncer for the slide-switch bank.
// Drives a clean registered switch vector plus one-cycle rise/fall/changed pulses.
module switch_debounce #(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           clean_q, clean_d;
    logic [WIDTH-1:0]           rise_q, rise_d;
    logic [WIDTH-1:0]           fall_q, fall_d;
    logic                       changed_q;

    // Plain flop chain: stage 0 takes the raw pin, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], switch};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_out[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CntMax) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                // Final differing cycle: commit the new level instead of wrapping.
                cnt_d[i]   = '0;
                clean_d[i] = sync_out[i];
                rise_d[i]  = sync_out[i];
                fall_d[i]  = ~sync_out[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign switch_clean = clean_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign changed      = changed_q;

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input-side conditioner for the board's slide-switch bank.
- Synchronises each asynchronous mechanical switch into the clk domain and debounces it with a per-bit stability counter.
- Presents a clean registered switch vector plus one-cycle rise, fall and changed pulses.
- Sits between the physical switch pins and any downstream logic that consumes the switch vector (e.g. the switch-to-LED mapping blocks).

Parameters:
- WIDTH, 6, number of switch bits.
- STABLE_CYCLES, 16, consecutive clk cycles a synchronised bit must differ from its output before the output follows it (legal range 2..65535).
- SYNC_STAGES, 2, synchroniser flop depth per bit (legal range 2..4).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock; reset polarity and asynchronous behaviour are fixed.
- switch  input  WIDTH  raw asynchronous switch levels.
- switch_clean  output  WIDTH  debounced, registered switch vector.
- rise  output  WIDTH  per-bit one-cycle pulse: switch_clean bit went 0->1 this cycle.
- fall  output  WIDTH  per-bit one-cycle pulse: switch_clean bit went 1->0 this cycle.
- changed  output  1  one-cycle pulse, OR of all rise and fall bits, aligned with them.

Behaviour:
- Reset (rst_n low, asynchronous assert, released at a clk edge):
  - All synchroniser flops, counters, switch_clean, rise, fall and changed are cleared to 0.
  - Reset asserted mid-count discards the partial count; no pulse is emitted.
- Synchroniser:
  - Per bit, a chain of SYNC_STAGES flops; sync_out is the last stage.
  - No logic between the stages.
- Per-bit counter:
  - Width is clog2(STABLE_CYCLES).
  - Each edge: if sync_out == switch_clean, counter <= 0.
  - Else if counter < STABLE_CYCLES-1, counter increments.
  - Else (counter == STABLE_CYCLES-1): switch_clean bit <= sync_out, counter <= 0, and the matching rise or fall bit is 1 for exactly that cycle.
- Latency:
  - A clean level change is sampled on edge E1 and appears on switch_clean after edge E(SYNC_STAGES+STABLE_CYCLES).
  - Defaults: 18 edges.
- Glitch rejection:
  - Any return of sync_out to switch_clean before the count completes clears the counter; switch_clean is unchanged and no pulse is emitted.
  - Bounce shorter than STABLE_CYCLES never propagates.
- Pulses:
  - rise, fall and changed are registered and high for one cycle only.
  - A bit can never assert rise and fall together.
  - Multiple bits completing on the same edge assert their bits simultaneously; changed is a single-cycle pulse.
- Bit independence:
  - Each bit's counter and output are independent.
  - Activity on one bit never delays or resets another.
- Steady state: with constant input, the counter holds 0, outputs are stable, and pulses stay 0.
- Counter wrap: the counter never wraps, because it saturates into the update-and-clear step.

Test Plan (bench uses STABLE_CYCLES=4, SYNC_STAGES=2, WIDTH=6, 10 ns clk):
- Reset then switch=6'b000000 held 20 cycles -> switch_clean=0; rise, fall and changed never assert.
- switch steps 0 -> 6'b000101 just before edge E1 -> switch_clean=6'b000101 after edge E6; rise=6'b000101 and changed=1 for exactly that one cycle; fall=0 throughout.
- Bit0 bounces 1,0,1,0 toggling every 2 cycles, then settles at 1 -> no update during the bounce; switch_clean[0]=1 six edges after the final settle edge, with a single rise[0] pulse.
- Bit3 set 0 -> 1 while bit1 falls 1 -> 0 on the same edge (from 6'b000010) -> both complete on the same edge: rise=6'b001000, fall=6'b000010, a single changed pulse, switch_clean=6'b001000.
- Counter at 3 on bit2 when rst_n is pulsed low between edges -> all outputs are 0 immediately and no pulse. After release with the input held at 1, the full six-edge latency is restarted from scratch.
- Incrementing switch pattern (0,1,2,...,63, one step every 10 cycles) -> switch_clean tracks each value six edges after it is applied; the changed count equals the number of value changes.
